// File: rtl/pattern_err_monitor_pkg.sv
// Shared definitions for the exhaustive pattern error monitor:
// the sweep FSM states and the Hamming-distance width helper.
`timescale 1ns/1ps
package pattern_err_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to hold a Hamming distance in the range 0..num_out.
  function automatic int hd_width(input int num_out);
    return $clog2(num_out + 1);
  endfunction

endpackage

// File: rtl/pattern_err_monitor_popcount.sv
// Purely combinational population count of a mismatch vector.
`timescale 1ns/1ps
module popcount_tree #(
  parameter int WIDTH = 26,
  parameter int HDW   = 5
) (
  input  logic [WIDTH-1:0] d,
  output logic [HDW-1:0]   count
);

  // Sum of set bits; synthesis rebalances the adder chain into a tree.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + HDW'(d[i]);
    end
  end

endmodule

// File: rtl/pattern_err_monitor.sv
// Drives every input pattern once to an exact and an approximate copy of a
// control circuit and accumulates error statistics over the whole sweep.
`timescale 1ns/1ps
module pattern_err_monitor
  import pattern_err_monitor_pkg::*;
#(
  parameter int NUM_IN  = 7,
  parameter int NUM_OUT = 26,
  localparam int HDW    = hd_width(NUM_OUT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic [NUM_IN-1:0]     pi_o,
  input  logic [NUM_OUT-1:0]    po_exact_i,
  input  logic [NUM_OUT-1:0]    po_approx_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [NUM_IN:0]       err_count_o,
  output logic [NUM_IN+HDW-1:0] bit_err_total_o,
  output logic [HDW-1:0]        max_hd_o,
  output logic [NUM_OUT-1:0]    err_mask_o
);

  localparam int CW = NUM_IN + 1;
  localparam int TW = NUM_IN + HDW;

  state_t              state_reg, state_next;
  logic [NUM_IN-1:0]   pi_reg, pi_next;
  logic [CW-1:0]       err_count_reg, err_count_next;
  logic [TW-1:0]       bit_err_total_reg, bit_err_total_next;
  logic [HDW-1:0]      max_hd_reg, max_hd_next;
  logic [NUM_OUT-1:0]  err_mask_reg, err_mask_next;

  logic [NUM_OUT-1:0]  diff;
  logic [HDW-1:0]      hd;

  assign diff = po_exact_i ^ po_approx_i;

  popcount_tree #(
    .WIDTH (NUM_OUT),
    .HDW   (HDW)
  ) u_popcount (
    .d     (diff),
    .count (hd)
  );

  // State and accumulator registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      pi_reg            <= '0;
      err_count_reg     <= '0;
      bit_err_total_reg <= '0;
      max_hd_reg        <= '0;
      err_mask_reg      <= '0;
    end else begin
      state_reg         <= state_next;
      pi_reg            <= pi_next;
      err_count_reg     <= err_count_next;
      bit_err_total_reg <= bit_err_total_next;
      max_hd_reg        <= max_hd_next;
      err_mask_reg      <= err_mask_next;
    end
  end

  // Next state and next accumulator values; everything holds by default.
  always_comb begin
    state_next         = state_reg;
    pi_next            = pi_reg;
    err_count_next     = err_count_reg;
    bit_err_total_next = bit_err_total_reg;
    max_hd_next        = max_hd_reg;
    err_mask_next      = err_mask_reg;

    unique case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next         = SWEEP;
          pi_next            = '0;
          err_count_next     = '0;
          bit_err_total_next = '0;
          max_hd_next        = '0;
          err_mask_next      = '0;
        end
      end
      SWEEP: begin
        if (abort_i) begin
          state_next         = IDLE;
          pi_next            = '0;
          err_count_next     = '0;
          bit_err_total_next = '0;
          max_hd_next        = '0;
          err_mask_next      = '0;
        end else begin
          // start_i is deliberately ignored while sweeping.
          err_count_next     = err_count_reg + CW'(|diff);
          bit_err_total_next = bit_err_total_reg + TW'(hd);
          max_hd_next        = (hd > max_hd_reg) ? hd : max_hd_reg;
          err_mask_next      = err_mask_reg | diff;
          // Last pattern wraps pi back to zero naturally.
          pi_next            = pi_reg + NUM_IN'(1);
          if (pi_reg == {NUM_IN{1'b1}}) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (abort_i) begin
          state_next         = IDLE;
          pi_next            = '0;
          err_count_next     = '0;
          bit_err_total_next = '0;
          max_hd_next        = '0;
          err_mask_next      = '0;
        end else if (start_i) begin
          state_next         = SWEEP;
          pi_next            = '0;
          err_count_next     = '0;
          bit_err_total_next = '0;
          max_hd_next        = '0;
          err_mask_next      = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pi_o            = pi_reg;
  assign busy_o          = (state_reg == SWEEP);
  assign done_o          = (state_reg == DONE);
  assign err_count_o     = err_count_reg;
  assign bit_err_total_o = bit_err_total_reg;
  assign max_hd_o        = max_hd_reg;
  assign err_mask_o      = err_mask_reg;

endmodule

// File: tb/tb_pattern_err_monitor.sv
// Self-checking bench for pattern_err_monitor: the circuit pair is emulated
// by lookup tables, and expected statistics come from a table-level model.
`timescale 1ns/1ps
module tb_pattern_err_monitor;

  localparam int NI  = 7;
  localparam int NO  = 26;
  localparam int HW  = 5;
  localparam int NP  = 1 << NI;

  logic           clk = 1'b0;
  logic           rst_n, start_i, abort_i;
  logic [NI-1:0]  pi_o;
  logic [NO-1:0]  po_exact, po_approx;
  logic           busy_o, done_o;
  logic [NI:0]    err_count_o;
  logic [NI+HW-1:0] bit_err_total_o;
  logic [HW-1:0]  max_hd_o;
  logic [NO-1:0]  err_mask_o;

  logic [NO-1:0]  exact_tbl [NP];
  logic [NO-1:0]  err_tbl   [NP];

  int n_assert = 0;
  int n_fail   = 0;

  // Expected results of the current table set.
  int             exp_cnt, exp_tot, exp_max;
  logic [NO-1:0]  exp_mask;

  always #5 clk = ~clk;

  assign po_exact  = exact_tbl[pi_o];
  assign po_approx = exact_tbl[pi_o] ^ err_tbl[pi_o];

  pattern_err_monitor #(.NUM_IN(NI), .NUM_OUT(NO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .pi_o            (pi_o),
    .po_exact_i      (po_exact),
    .po_approx_i     (po_approx),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_count_o     (err_count_o),
    .bit_err_total_o (bit_err_total_o),
    .max_hd_o        (max_hd_o),
    .err_mask_o      (err_mask_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Statistics over all patterns, straight from the mismatch table.
  task automatic model();
    exp_cnt = 0; exp_tot = 0; exp_max = 0; exp_mask = '0;
    for (int p = 0; p < NP; p++) begin
      int h;
      h = $countones(err_tbl[p]);
      if (h != 0) exp_cnt++;
      exp_tot += h;
      if (h > exp_max) exp_max = h;
      exp_mask |= err_tbl[p];
    end
  endtask

  task automatic fill(input int mode);
    for (int p = 0; p < NP; p++) begin
      exact_tbl[p] = NO'($urandom);
      case (mode)
        0: err_tbl[p] = '0;
        1: err_tbl[p] = NO'(32'h8);
        2: err_tbl[p] = {NO{1'b1}};
        3: err_tbl[p] = (p == 'h55) ? NO'(32'h1F) : '0;
        default: err_tbl[p] = ($urandom_range(0, 3) == 0) ? NO'($urandom) : '0;
      endcase
    end
    model();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, 64'(busy_o), 64'd0);
    chk({tag, ".done"}, 64'(done_o), 64'd0);
    chk({tag, ".pi"},   64'(pi_o), 64'd0);
    chk({tag, ".cnt"},  64'(err_count_o), 64'd0);
    chk({tag, ".tot"},  64'(bit_err_total_o), 64'd0);
    chk({tag, ".max"},  64'(max_hd_o), 64'd0);
    chk({tag, ".mask"}, 64'(err_mask_o), 64'd0);
  endtask

  task automatic chk_results(input string tag);
    chk({tag, ".done"}, 64'(done_o), 64'd1);
    chk({tag, ".busy"}, 64'(busy_o), 64'd0);
    chk({tag, ".pi"},   64'(pi_o), 64'd0);
    chk({tag, ".cnt"},  64'(err_count_o), 64'(exp_cnt));
    chk({tag, ".tot"},  64'(bit_err_total_o), 64'(exp_tot));
    chk({tag, ".max"},  64'(max_hd_o), 64'(exp_max));
    chk({tag, ".mask"}, 64'(err_mask_o), 64'(exp_mask));
  endtask

  // One full sweep from IDLE or DONE: the start edge plus one edge per
  // pattern, so done appears after edge number NP+1 counting the start edge.
  task automatic run_sweep(input string tag, input bit hold_start);
    start_i = 1'b1;
    tick();
    if (!hold_start) start_i = 1'b0;
    chk({tag, ".first_busy"}, 64'(busy_o), 64'd1);
    chk({tag, ".first_pi"},   64'(pi_o), 64'd0);
    chk({tag, ".first_cnt"},  64'(err_count_o), 64'd0);
    for (int k = 1; k < NP; k++) begin
      tick();
      if (k == 100) start_i = 1'b0;
      chk({tag, ".pi_step"},   64'(pi_o), 64'(k));
      chk({tag, ".busy_step"}, 64'(busy_o), 64'd1);
      chk({tag, ".done_early"}, 64'(done_o), 64'd0);
    end
    start_i = 1'b0;
    tick();
    chk_results(tag);
    $display("sweep %s: cnt=%0d tot=%0d max=%0d mask=0x%07h", tag,
             err_count_o, bit_err_total_o, max_hd_o, err_mask_o);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    fill(0);
    tick(); tick();
    chk_zero("reset");
    $display("reset: all outputs checked");

    // First edge with rst_n high already accepts start.
    rst_n = 1'b1;
    run_sweep("equal", 1'b0);

    fill(1);
    run_sweep("bit3", 1'b0);
    chk("bit3.cnt_const",  64'(err_count_o), 64'd128);
    chk("bit3.mask_const", 64'(err_mask_o), 64'h8);

    fill(2);
    run_sweep("invert", 1'b0);
    chk("invert.tot_const", 64'(bit_err_total_o), 64'd3328);
    chk("invert.max_const", 64'(max_hd_o), 64'd26);

    fill(3);
    run_sweep("single55", 1'b0);
    chk("single55.tot_const", 64'(bit_err_total_o), 64'd5);

    // Results stay stable in DONE.
    for (int k = 0; k < 5; k++) tick();
    chk_results("hold");
    $display("hold: DONE results unchanged");

    // Reset while pi_o is 40, then a fresh run must match a clean one.
    fill(4);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    begin
      int guard = 0;
      while (pi_o != 40 && guard < 300) begin
        tick();
        guard++;
      end
      chk("midreset.reach40", 64'(pi_o), 64'd40);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_zero("midreset");
    $display("midreset: outputs cleared");
    run_sweep("after_reset", 1'b0);

    // start held through most of the sweep, then restart from DONE.
    fill(4);
    run_sweep("held_start", 1'b1);
    run_sweep("restart", 1'b0);

    // abort together with start in SWEEP.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    abort_i = 1'b1; start_i = 1'b1;
    tick();
    abort_i = 1'b0; start_i = 1'b0;
    chk_zero("abort_sweep");
    $display("abort_sweep: back to IDLE");

    // abort in DONE.
    run_sweep("pre_abort", 1'b0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk_zero("abort_done");
    $display("abort_done: back to IDLE");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
